seven_seg_capture: RTL and testbench

- Receive-side counterpart of the 4-digit multiplexed seven-segment driver.
- Samples the scanned cathode/anode signals, debounces each digit's dwell, and decodes the segment patterns back to BCD.
- Assembles one full frame of four digits and converts it to binary.
- Used for loopback self-check of the display path and for decoding external scanned displays into a number.

---
 rtl/seven_seg_pkg.sv | 25 ++
 rtl/seven_seg_digit_decode.sv | 30 +++
 rtl/seven_seg_capture.sv | 216 +++++++++++++++++++++
 tb/tb_seven_seg_capture.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment capture path: active-low {g..a} digit patterns,
// digit count and the frame FSM state type.
package seven_seg_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    StCollect,
    StConvert,
    StDone
  } cap_state_e;

endpackage

// File: rtl/seven_seg_digit_decode.sv
// Combinational active-low segment pattern to BCD decoder; blank reads as 0 without error,
// any other unknown pattern reads as 0 and raises invalid_o.
module seven_seg_digit_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] bcd_o,
  output logic       invalid_o
);

  always_comb begin
    bcd_o     = 4'd0;
    invalid_o = 1'b0;
    case (seg_i)
      SEG_0:     bcd_o = 4'd0;
      SEG_1:     bcd_o = 4'd1;
      SEG_2:     bcd_o = 4'd2;
      SEG_3:     bcd_o = 4'd3;
      SEG_4:     bcd_o = 4'd4;
      SEG_5:     bcd_o = 4'd5;
      SEG_6:     bcd_o = 4'd6;
      SEG_7:     bcd_o = 4'd7;
      SEG_8:     bcd_o = 4'd8;
      SEG_9:     bcd_o = 4'd9;
      SEG_BLANK: bcd_o = 4'd0;
      default:   invalid_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Receive side of a 4-digit scanned seven-segment display: debounces each digit dwell, decodes
// it to BCD and converts a full frame to binary. Define SEG_CAPTURE_DP_EN to capture dp bits.
module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned VALUE_W       = 14
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         segmentDisplay,
  input  logic [3:0]         an,
  input  logic               dp,
  output logic [VALUE_W-1:0] value,
  output logic               valid,
  output logic               seg_err,
  output logic [3:0]         dp_pos
);

  localparam int unsigned     CntW   = $clog2(STABLE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES - 1);

  logic [3:0]            an_q, an_prev_q;
  logic [6:0]            seg_q, seg_prev_q;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  captured_q, captured_d;
  logic [NUM_DIGITS-1:0] mask_q, mask_d, mask_w, cap_onehot;
  logic [3:0]            slot_q [NUM_DIGITS];
  logic [3:0]            slot_d [NUM_DIGITS];
  logic [3:0]            slot_w [NUM_DIGITS];
  logic [3:0]            snap_slot_q [NUM_DIGITS];
  logic [3:0]            snap_slot_d [NUM_DIGITS];
  logic                  err_q, err_d, err_w, snap_err_q, snap_err_d;
  cap_state_e            state_q, state_d;
  logic [1:0]            step_q, step_d, conv_idx;
  logic [VALUE_W-1:0]    acc_q, acc_d, value_q, value_d;
  logic                  valid_q, valid_d, seg_err_q, seg_err_d;
  logic                  legal, same, capture, snap_held, snap_new;
  logic [1:0]            idx;
  logic [3:0]            dec_bcd;
  logic                  dec_invalid;

  seven_seg_digit_decode u_decode (
    .seg_i     (seg_q),
    .bcd_o     (dec_bcd),
    .invalid_o (dec_invalid)
  );

  always_comb begin
    legal = 1'b1;
    idx   = 2'd0;
    case (an_q)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: legal = 1'b0;
    endcase
  end

  assign same = legal && (an_q == an_prev_q) && (seg_q == seg_prev_q);

  // The captured flag makes a long dwell produce exactly one capture.
  always_comb begin
    cnt_d      = '0;
    captured_d = 1'b0;
    capture    = 1'b0;
    if (same) begin
      cnt_d      = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
      capture    = !captured_q && (cnt_d == CntMax);
      captured_d = captured_q | capture;
    end
  end

  always_comb begin
    slot_w     = slot_q;
    cap_onehot = '0;
    if (capture) begin
      slot_w[idx]     = dec_bcd;
      cap_onehot[idx] = 1'b1;
    end
    err_w  = err_q | (capture & dec_invalid);
    mask_w = mask_q | cap_onehot;
    // snap_held covers a frame that filled up while the converter was still busy.
    snap_held = (state_q == StCollect) && (mask_q == '1);
    snap_new  = (state_q == StCollect) && !snap_held && (mask_w == '1);
  end

  assign conv_idx = 2'd3 - step_q;

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    acc_d       = acc_q;
    mask_d      = mask_w;
    err_d       = err_w;
    slot_d      = slot_w;
    snap_slot_d = snap_slot_q;
    snap_err_d  = snap_err_q;
    value_d     = value_q;
    seg_err_d   = seg_err_q;
    valid_d     = 1'b0;
    case (state_q)
      StCollect: begin
        if (snap_held) begin
          snap_slot_d = slot_q;
          snap_err_d  = err_q;
          mask_d      = cap_onehot;
          err_d       = capture & dec_invalid;
        end else if (snap_new) begin
          snap_slot_d = slot_w;
          snap_err_d  = err_w;
          mask_d      = '0;
          err_d       = 1'b0;
        end
        if (snap_held || snap_new) begin
          state_d = StConvert;
          step_d  = 2'd0;
          acc_d   = '0;
        end
      end
      StConvert: begin
        acc_d  = (acc_q << 3) + (acc_q << 1) + VALUE_W'(snap_slot_q[conv_idx]);
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) state_d = StDone;
      end
      StDone: begin
        value_d   = acc_q;
        seg_err_d = snap_err_q;
        valid_d   = 1'b1;
        state_d   = StCollect;
      end
      default: state_d = StCollect;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_q        <= 4'hF;
      an_prev_q   <= 4'hF;
      seg_q       <= SEG_BLANK;
      seg_prev_q  <= SEG_BLANK;
      cnt_q       <= '0;
      captured_q  <= 1'b0;
      mask_q      <= '0;
      slot_q      <= '{default: '0};
      err_q       <= 1'b0;
      snap_slot_q <= '{default: '0};
      snap_err_q  <= 1'b0;
      state_q     <= StCollect;
      step_q      <= 2'd0;
      acc_q       <= '0;
      value_q     <= '0;
      seg_err_q   <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      an_q        <= an;
      an_prev_q   <= an_q;
      seg_q       <= segmentDisplay;
      seg_prev_q  <= seg_q;
      cnt_q       <= cnt_d;
      captured_q  <= captured_d;
      mask_q      <= mask_d;
      slot_q      <= slot_d;
      err_q       <= err_d;
      snap_slot_q <= snap_slot_d;
      snap_err_q  <= snap_err_d;
      state_q     <= state_d;
      step_q      <= step_d;
      acc_q       <= acc_d;
      value_q     <= value_d;
      seg_err_q   <= seg_err_d;
      valid_q     <= valid_d;
    end
  end

  assign value   = value_q;
  assign valid   = valid_q;
  assign seg_err = seg_err_q;

`ifdef SEG_CAPTURE_DP_EN
  logic                  dp_q;
  logic [NUM_DIGITS-1:0] dpm_q, dpm_d, snap_dp_q, snap_dp_d, dp_pos_q, dp_pos_d;

  // Slots are rewritten every frame, so the per-digit dp bits never need clearing.
  always_comb begin
    dpm_d = dpm_q;
    if (capture) dpm_d[idx] = ~dp_q;
    snap_dp_d = snap_dp_q;
    if (snap_held)     snap_dp_d = dpm_q;
    else if (snap_new) snap_dp_d = dpm_d;
    dp_pos_d = (state_q == StDone) ? snap_dp_q : dp_pos_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dp_q      <= 1'b1;
      dpm_q     <= '0;
      snap_dp_q <= '0;
      dp_pos_q  <= '0;
    end else begin
      dp_q      <= dp;
      dpm_q     <= dpm_d;
      snap_dp_q <= snap_dp_d;
      dp_pos_q  <= dp_pos_d;
    end
  end

  assign dp_pos = dp_pos_q;
`else
  logic unused_dp;
  assign unused_dp = dp;
  assign dp_pos    = 4'b0000;
`endif

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench for seven_seg_capture: scans hand-built frames and checks value, latency,
// error and dp reporting against hand-computed results.
module tb_seven_seg_capture;

  localparam int unsigned VALUE_W = 14;

`ifdef SEG_CAPTURE_DP_EN
  localparam logic [3:0] DpExp = 4'b0100;
`else
  localparam logic [3:0] DpExp = 4'b0000;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic [6:0]         seg;
  logic [3:0]         an;
  logic               dp;
  logic [VALUE_W-1:0] value;
  logic               valid;
  logic               seg_err;
  logic [3:0]         dp_pos;

  int n_cmp  = 0;
  int n_fail = 0;
  int vcount = 0;

  seven_seg_capture #(
    .STABLE_CYCLES (4),
    .VALUE_W       (VALUE_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .segmentDisplay (seg),
    .an             (an),
    .dp             (dp),
    .value          (value),
    .valid          (valid),
    .seg_err        (seg_err),
    .dp_pos         (dp_pos)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] pat(input int d);
    case (d)
      0:       return 7'b1000000;
      1:       return 7'b1111001;
      2:       return 7'b0100100;
      3:       return 7'b0110000;
      4:       return 7'b0011001;
      5:       return 7'b0010010;
      6:       return 7'b0000010;
      7:       return 7'b1111000;
      8:       return 7'b0000000;
      9:       return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one anode for n cycles, counting every valid pulse seen along the way.
  task automatic dwell(input int d_idx, input logic [6:0] s, input logic dp_lit, input int n);
    an        = 4'hF;
    an[d_idx] = 1'b0;
    seg       = s;
    dp        = ~dp_lit;
    repeat (n) begin
      @(negedge clk);
      if (valid) vcount++;
    end
  endtask

  task automatic blank(input int n);
    an  = 4'hF;
    seg = 7'b1111111;
    dp  = 1'b1;
    repeat (n) begin
      @(negedge clk);
      if (valid) vcount++;
    end
  endtask

  // Called at the 10th negedge of the last digit: capture was in cycle 4, so valid is due now.
  task automatic finish_frame(input string tag, input int exp_v, input logic exp_e,
                              input logic [3:0] exp_dp);
    check({tag, "_valid_at_latency"}, valid, 1);
    check({tag, "_single_valid"}, vcount, 1);
    check({tag, "_value"}, value, exp_v);
    check({tag, "_seg_err"}, seg_err, exp_e);
    check({tag, "_dp_pos"}, dp_pos, exp_dp);
    @(negedge clk);
    check({tag, "_valid_pulse"}, valid, 0);
    blank(3);
  endtask

  task automatic frame_test(input string tag, input logic [6:0] s3, input logic [6:0] s2,
                            input logic [6:0] s1, input logic [6:0] s0, input logic [3:0] dpl,
                            input int exp_v, input logic exp_e, input logic [3:0] exp_dp);
    vcount = 0;
    dwell(3, s3, dpl[3], 10);
    dwell(2, s2, dpl[2], 10);
    dwell(1, s1, dpl[1], 10);
    dwell(0, s0, dpl[0], 10);
    finish_frame(tag, exp_v, exp_e, exp_dp);
  endtask

  initial begin
    reset = 1'b1;
    an    = 4'hF;
    seg   = 7'b1111111;
    dp    = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_value", value, 0);
    check("rst_valid", valid, 0);
    check("rst_seg_err", seg_err, 0);
    check("rst_dp_pos", dp_pos, 0);

    frame_test("lb13", pat(-1), pat(-1), pat(1), pat(3), 4'b0000, 13, 1'b0, 4'b0000);
    frame_test("lb8191", pat(8), pat(1), pat(9), pat(1), 4'b0000, 8191, 1'b0, 4'b0000);
    frame_test("scan1234", pat(1), pat(2), pat(3), pat(4), 4'b0000, 1234, 1'b0, 4'b0000);

    vcount = 0;
    dwell(3, pat(1), 1'b0, 10);
    dwell(2, pat(7), 1'b0, 6);
    dwell(2, 7'b0100100, 1'b0, 2);
    dwell(2, pat(7), 1'b0, 6);
    dwell(1, pat(0), 1'b0, 10);
    dwell(0, pat(5), 1'b0, 10);
    finish_frame("glitch", 1705, 1'b0, 4'b0000);

    frame_test("bad_seg", pat(1), pat(2), 7'b0101010, pat(4), 4'b0000, 1204, 1'b1, 4'b0000);
    frame_test("clean", pat(4), pat(3), pat(2), pat(1), 4'b0000, 4321, 1'b0, 4'b0000);
    frame_test("dp", pat(9), pat(8), pat(7), pat(6), 4'b0100, 9876, 1'b0, DpExp);

    // Three digits captured, then reset: nothing may be reported and the mask must restart.
    vcount = 0;
    dwell(0, pat(4), 1'b0, 10);
    dwell(1, pat(3), 1'b0, 10);
    dwell(2, pat(2), 1'b0, 10);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_value", value, 0);
    check("mid_rst_seg_err", seg_err, 0);
    check("mid_rst_dp_pos", dp_pos, 0);
    blank(15);
    check("mid_rst_no_valid", vcount, 0);
    frame_test("post_rst", pat(5), pat(6), pat(7), pat(8), 4'b0000, 5678, 1'b0, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
